// File: rtl/wb_cernbe_bridge_if.sv
// Bundle of the Wishbone slave side and CERN-BE master side of wb_cernbe_bridge.
// slave modport is the bridge's view; master modport is the view of whatever drives the bridge.
interface wb_cernbe_bridge_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  wb_cyc_i;
    logic                  wb_stb_i;
    logic                  wb_we_i;
    logic [ADDR_WIDTH-3:0] wb_adr_i;
    logic [31:0]           wb_dat_i;
    logic [31:0]           wb_dat_o;
    logic                  wb_ack_o;
    logic                  wb_err_o;
    logic                  wb_stall_o;

    logic [ADDR_WIDTH-3:0] VMEAddr;
    logic [31:0]           VMEWrData;
    logic                  VMERdMem;
    logic                  VMEWrMem;
    logic [31:0]           VMERdData;
    logic                  VMERdDone;
    logic                  VMEWrDone;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o,
        output VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
        input  VMERdData, VMERdDone, VMEWrDone
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o,
        input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
        output VMERdData, VMERdDone, VMEWrDone
    );
endinterface

// File: rtl/wb_cernbe_bridge.sv
// Single-outstanding pipelined-Wishbone to CERN-BE memory bus bridge.
// Optional Done timeout enabled by defining WB_CERNBE_BRIDGE_TIMEOUT_EN.
module wb_cernbe_bridge #(
    parameter int ADDR_WIDTH = 3,
    parameter int TIMEOUT    = 255
) (
    input logic               Clk,
    input logic               rst_n,
    wb_cernbe_bridge_if.slave bus
);
    localparam int AW = ADDR_WIDTH - 2;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("wb_cernbe_bridge: TIMEOUT must be >= 2");
    end

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          dir_q, dir_d;
    logic          abort_q, abort_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          match;
    logic          abort_now;

`ifdef WB_CERNBE_BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Only the Done matching the latched direction completes the access.
    assign match     = dir_q ? bus.VMEWrDone : bus.VMERdDone;
    // A dropped cyc in the current WAIT cycle already counts as an abort.
    assign abort_now = abort_q | ~bus.wb_cyc_i;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        dir_d   = dir_q;
        abort_d = abort_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
`ifdef WB_CERNBE_BRIDGE_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (bus.wb_cyc_i && bus.wb_stb_i) begin
                    addr_d  = bus.wb_adr_i;
                    wdata_d = bus.wb_dat_i;
                    dir_d   = bus.wb_we_i;
                    rd_d    = ~bus.wb_we_i;
                    wr_d    = bus.wb_we_i;
                    state_d = S_WAIT;
`ifdef WB_CERNBE_BRIDGE_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                abort_d = abort_now;
                if (match) begin
                    state_d = S_IDLE;
                    abort_d = 1'b0;
                    ack_d   = ~abort_now;
                    if (!dir_q && !abort_now)
                        rdata_d = bus.VMERdData;
                end
`ifdef WB_CERNBE_BRIDGE_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d = S_IDLE;
                    abort_d = 1'b0;
                    err_d   = ~abort_now;
                    if (!abort_now)
                        rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            dir_q   <= 1'b0;
            abort_q <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef WB_CERNBE_BRIDGE_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            dir_q   <= dir_d;
            abort_q <= abort_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
`ifdef WB_CERNBE_BRIDGE_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.wb_dat_o   = rdata_q;
    assign bus.wb_ack_o   = ack_q;
    assign bus.wb_err_o   = err_q;
    assign bus.wb_stall_o = (state_q == S_WAIT);
    assign bus.VMEAddr    = addr_q;
    assign bus.VMEWrData  = wdata_q;
    assign bus.VMERdMem   = rd_q;
    assign bus.VMEWrMem   = wr_q;
endmodule
